// File: rtl/run_ctrl_if.sv
//==============================================================================
// run_ctrl_if : request/status bundle between the debug KEY logic and run_ctrl.
// Optional macro: RUN_CTRL_RETIRE_CNT_EN adds the 32-bit retired count.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface run_ctrl_if #(
  parameter int DBITS = 32
);
  logic             runReq;
  logic             haltReq;
  logic             stepReq;
  logic             bpEn;
  logic [DBITS-1:0] bpAddr;
  logic [DBITS-1:0] pcOut;
  logic             commitEn;
  logic             running;
  logic             halted;
  logic             bpHit;
`ifdef RUN_CTRL_RETIRE_CNT_EN
  logic [31:0]      retired;
`endif

  modport master (
    output runReq,
    output haltReq,
    output stepReq,
    output bpEn,
    output bpAddr,
    output pcOut,
    input  commitEn,
    input  running,
    input  halted,
    input  bpHit
`ifdef RUN_CTRL_RETIRE_CNT_EN
    , input retired
`endif
  );

  modport slave (
    input  runReq,
    input  haltReq,
    input  stepReq,
    input  bpEn,
    input  bpAddr,
    input  pcOut,
    output commitEn,
    output running,
    output halted,
    output bpHit
`ifdef RUN_CTRL_RETIRE_CNT_EN
    , output retired
`endif
  );
endinterface

`default_nettype wire

// File: rtl/run_ctrl.sv
//==============================================================================
// run_ctrl : run/halt/single-step/breakpoint gate for architectural commits.
// Optional macro: RUN_CTRL_RETIRE_CNT_EN enables the retired-instruction counter.
// Revision: 1.0
//==============================================================================
`default_nettype none

module run_ctrl #(
  parameter int DBITS     = 32,
  parameter bit START_RUN = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BPHIT = 2'd3
  } state_t;

  localparam state_t c_RESET_STATE = START_RUN ? S_RUN : S_HALT;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_skip_bp;
  logic             r_running;
  logic             r_halted;
  logic             r_bp_hit;
  logic [DBITS-1:0] w_pc;
  logic [DBITS-1:0] w_bp_addr;
  logic             w_bp_match;
  logic             w_commit;

  assign w_pc       = bus.pcOut;
  assign w_bp_addr  = bus.bpAddr;
  assign w_bp_match = bus.bpEn && (w_pc == w_bp_addr) && !r_skip_bp;
  assign w_commit   = ((r_state == S_RUN) && !w_bp_match) || (r_state == S_STEP);

  // Coincident pulses resolve as halt > step > run.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HALT: begin
        if (bus.stepReq)     w_state_nxt = S_STEP;
        else if (bus.runReq) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.haltReq)     w_state_nxt = S_HALT;
        else if (w_bp_match) w_state_nxt = S_BPHIT;
      end
      S_STEP: w_state_nxt = S_HALT;
      S_BPHIT: begin
        if (bus.haltReq)      w_state_nxt = S_HALT;
        else if (bus.stepReq) w_state_nxt = S_STEP;
        else if (bus.runReq)  w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // skipBp lives only for the first RUN cycle after leaving a breakpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_RESET_STATE;
      r_skip_bp <= 1'b0;
      r_running <= START_RUN;
      r_halted  <= !START_RUN;
      r_bp_hit  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_skip_bp <= (r_state == S_BPHIT) && (w_state_nxt == S_RUN);
      r_running <= (w_state_nxt == S_RUN);
      r_halted  <= (w_state_nxt == S_HALT) || (w_state_nxt == S_BPHIT);
      r_bp_hit  <= (w_state_nxt == S_BPHIT);
    end
  end

  assign bus.commitEn = w_commit;
  assign bus.running  = r_running;
  assign bus.halted   = r_halted;
  assign bus.bpHit    = r_bp_hit;

`ifdef RUN_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset)         r_retired <= 32'd0;
    else if (w_commit) r_retired <= r_retired + 32'd1;
  end

  assign bus.retired = r_retired;
`endif

endmodule

`default_nettype wire

// File: doc/run_ctrl.md
# run_ctrl

Run/halt/single-step/breakpoint controller for the single-cycle processor. It sits between the debounced KEY inputs and the datapath's architectural-state write enables: PC write, register-file write and data-memory write. It produces one `commitEn` that the top level ANDs into `pcWrtEn`, `wrtEnReg` and `wrEnMem`. Lets the team stop the core on a hardware PC breakpoint, single-step it, and resume it without reprogramming the board.

## Interface
Parameters:
- `DBITS`, 32, PC/address width.
- `START_RUN`, 1, state after reset: 1 = RUN, 0 = HALT.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `runReq`  in  1  one-cycle pulse: request free-running execution.
- `haltReq`  in  1  one-cycle pulse: request stop.
- `stepReq`  in  1  one-cycle pulse: request exactly one instruction.
- `bpEn`  in  1  breakpoint enable (level).
- `bpAddr`  in  DBITS  breakpoint PC, byte address.
- `pcOut`  in  DBITS  current PC from the fetch stage.
- `commitEn`  out  1  instruction at `pcOut` commits this cycle.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT or BPHIT.
- `bpHit`  out  1  state == BPHIT.
- `retired`  out  32  committed-instruction count. Present only with `RUN_CTRL_RETIRE_CNT_EN`.

## Operation
- Four states: HALT, RUN, STEP, BPHIT. All are encoded in a registered state register.
- Breakpoint match:
  - `bpMatch` = `bpEn && pcOut == bpAddr && !skipBp`.
  - The compare is combinational, full DBITS width, with no masking.
- `skipBp` register:
  - Set on the transition BPHIT→RUN.
  - Cleared after the first RUN cycle.
  - Purpose: the breakpointed instruction executes once on resume.
- `commitEn` = `(state==RUN && !bpMatch) || state==STEP`.
  - It is combinational from state, `skipBp` and `pcOut`.
- Request priority when pulses coincide: `haltReq` > `stepReq` > `runReq`.
- Transitions, evaluated at each rising edge:
  - HALT:
    - `stepReq` → STEP.
    - `runReq` → RUN.
    - Otherwise stay in HALT.
  - RUN:
    - `haltReq` → HALT.
    - `bpMatch` → BPHIT.
    - Otherwise stay in RUN. `stepReq` and `runReq` are ignored.
  - STEP:
    - Always → HALT after its single cycle.
    - Any request during STEP is dropped.
    - STEP ignores breakpoints.
  - BPHIT:
    - `haltReq` → HALT.
    - `stepReq` → STEP.
    - `runReq` → RUN with `skipBp` set.
    - Otherwise stay in BPHIT.
- A RUN cycle in which `bpMatch` and `haltReq` coincide goes to HALT. Its `commitEn` is still 0 because of `bpMatch`.
- Changing `bpAddr`/`bpEn` while in RUN takes effect in the same cycle through the combinational compare.

## Timing
- Reset values:
  - state = RUN if `START_RUN` else HALT.
  - `skipBp`=0, `retired`=0.
  - `running`=`START_RUN`, `halted`=!`START_RUN`, `bpHit`=0.
  - `commitEn` follows state (1 after reset when `START_RUN`=1 and there is no breakpoint match).
- Request latency: a pulse sampled at edge N changes state at edge N. The new `commitEn` is visible in cycle N+1, so there is exactly one cycle of latency.
- A step yields exactly one cycle with `commitEn`=1, hence one PC advance.
- Breakpoint latency is zero: the matching instruction never commits.
- `reset` asserted in any state overrides all requests at that edge, including mid-STEP.
- `retired` wraps from 0xFFFFFFFF to 0.

## Configuration
- `RUN_CTRL_RETIRE_CNT_EN` defined:
  - 32-bit `retired` port and counter are present.
  - The counter increments on every edge where `commitEn`=1 and `reset`=0.
- Not defined:
  - The `retired` port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset with `START_RUN`=1, `bpEn`=0, PC sweeping 0x40..0x4C → `commitEn`=1 every cycle; `retired`=4 after 4 cycles.
- `bpEn`=1, `bpAddr`=0x48, RUN from 0x40 → commits at 0x40 and 0x44; `commitEn`=0 at 0x48; `bpHit`=1 from the next cycle; PC holds 0x48.
- From BPHIT at 0x48, pulse `runReq` → 0x48 commits once (`skipBp`); execution continues; the next return to 0x48 breaks again.
- From HALT, three `stepReq` pulses spaced 4 cycles apart → exactly three `commitEn` pulses; PC 0x40→0x4C; `retired`=3; state returns to HALT after each.
- Same-cycle `haltReq`+`stepReq`+`runReq` while in RUN → HALT; no commit in the following cycle.
- `reset` asserted during STEP with `START_RUN`=0 → HALT next cycle; `commitEn`=0; `retired`=0.
